// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives trial codes to an external
// R-2R DAC, reads the amplifier (used as a comparator) back through a
// two-flop synchroniser, and resolves one bit per settle+decide period.

module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] TOP_IDX     = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE,
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic             cmp_meta;
  logic             cmp_sync;
  logic [WIDTH-1:0] decided_code;
  logic [WIDTH-1:0] trial_code;

  // Two-flop synchroniser so only a settled comparator decision reaches the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta <= 1'b0;
      cmp_sync <= 1'b0;
    end else begin
      cmp_meta <= cmp_in;
      cmp_sync <= cmp_meta;
    end
  end

  // Current bit resolved by the comparator, and the next trial with the lower bit set
  always_comb begin
    decided_code          = dac_code;
    decided_code[bit_idx] = cmp_sync;
    trial_code            = decided_code;
    if (bit_idx != '0) begin
      trial_code[bit_idx - 1'b1] = 1'b1;
    end
  end

  // Conversion sequencer: accept, settle each trial, decide, publish the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dac_code   <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= '0;
      bit_idx    <= TOP_IDX;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start || continuous) begin
            dac_code   <= MSB_CODE;
            bit_idx    <= TOP_IDX;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= DECIDE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        DECIDE: begin
          if (bit_idx != '0) begin
            dac_code   <= trial_code;
            bit_idx    <= bit_idx - 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end else begin
            dac_code <= decided_code;
            result   <= decided_code;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (continuous) begin
            dac_code   <= MSB_CODE;
            bit_idx    <= TOP_IDX;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: an ideal comparator (V >= dac_code)
// closes the loop, and a binary-search model predicts trial codes and results.

module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       continuous;
  logic [7:0] v;
  logic       cmp_in;
  logic [7:0] dac_code;
  logic [7:0] result;
  logic       busy;
  logic       done;

  logic       start6;
  logic       cont6;
  logic [5:0] v6;
  logic       cmp6;
  logic [5:0] dac6;
  logic [5:0] result6;
  logic       busy6;
  logic       done6;

  int checks = 0;
  int fails  = 0;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Ideal comparator standing in for the amplifier
  assign cmp_in = (v >= dac_code);
  assign cmp6   = (v6 >= dac6);

  sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .cmp_in     (cmp_in),
    .dac_code   (dac_code),
    .result     (result),
    .busy       (busy),
    .done       (done)
  );

  sar_adc_ctrl #(.WIDTH(6), .SETTLE_CYCLES(2)) dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start6),
    .continuous (cont6),
    .cmp_in     (cmp6),
    .dac_code   (dac6),
    .result     (result6),
    .busy       (busy6),
    .done       (done6)
  );

  // k-th trial code of an ideal binary search for val at width w
  function automatic logic [7:0] sar_trial(input logic [7:0] val, input int w, input int k);
    logic [7:0] code;
    logic [7:0] trial;
    code  = 8'h00;
    trial = 8'h00;
    for (int i = 0; i <= k; i++) begin
      trial = code | (8'd1 << (w - 1 - i));
      if (i < k && val >= trial) code = trial;
    end
    return trial;
  endfunction

  // Waits for done on the 8-bit instance, counting falling edges
  task automatic wait_done(input int limit, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dac_code !== 8'h00) begin fails++; $display("[TB] FAIL reset_dac: got %0h expected 0", dac_code); end
    checks++; if (result !== 8'h00) begin fails++; $display("[TB] FAIL reset_result: got %0h expected 0", result); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (dac6 !== 6'h00 || busy6 !== 1'b0) begin fails++; $display("[TB] FAIL reset_dut6: got dac %0h busy %0b expected 0 0", dac6, busy6); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One start pulse, trial sequence, latency, result and post-done behaviour
  task automatic test_single(input logic [7:0] val);
    int         n;
    bit         seen;
    logic [7:0] exp_trial;
    v     = val;
    start = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (n <= 36 && (n - 1) % 5 == 0) begin
        exp_trial = sar_trial(val, 8, (n - 1) / 5);
        checks++;
        if (dac_code !== exp_trial) begin
          fails++;
          $display("[TB] FAIL trial_%0d (V=%0h): got %0h expected %0h", (n - 1) / 5, val, dac_code, exp_trial);
        end
      end
      if (done) seen = 1'b1;
    end
    checks++; if (!seen || n != 41) begin fails++; $display("[TB] FAIL latency (V=%0h): got %0d expected 40 (seen=%0b)", val, n - 1, seen); end
    checks++; if (result !== val) begin fails++; $display("[TB] FAIL result (V=%0h): got %0h expected %0h", val, result, val); end
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL busy_in_done (V=%0h): got %0b expected 1", val, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL after_done (V=%0h): got done %0b busy %0b expected 0 0", val, done, busy); end
    checks++; if (dac_code !== val) begin fails++; $display("[TB] FAIL dac_holds_result (V=%0h): got %0h expected %0h", val, dac_code, val); end
  endtask

  task automatic test_boundaries();
    test_single(8'h00);
    test_single(8'hFF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) test_single(8'($urandom_range(0, 255)));
  endtask

  task automatic test_start_held();
    int n;
    bit seen;
    v          = 8'h3C;
    continuous = 1'b0;
    start      = 1'b1;
    wait_done(60, n, seen);
    checks++; if (!seen || n != 41) begin fails++; $display("[TB] FAIL held_latency1: got %0d expected 40", n - 1); end
    checks++; if (result !== 8'h3C) begin fails++; $display("[TB] FAIL held_result1: got %0h expected 3c", result); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL held_idle_gap: got busy %0b expected 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || dac_code !== 8'h80) begin fails++; $display("[TB] FAIL held_restart: got busy %0b dac %0h expected 1 80", busy, dac_code); end
    n    = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    checks++; if (!seen || n != 40) begin fails++; $display("[TB] FAIL held_latency2: got %0d expected 40", n); end
    checks++; if (result !== 8'h3C) begin fails++; $display("[TB] FAIL held_result2: got %0h expected 3c", result); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL held_stop: got busy %0b expected 0", busy); end
  endtask

  task automatic test_continuous();
    int n;
    bit seen;
    v          = 8'h10;
    start      = 1'b0;
    continuous = 1'b1;
    wait_done(60, n, seen);
    checks++; if (!seen || n != 41) begin fails++; $display("[TB] FAIL cont_latency1: got %0d expected 40", n - 1); end
    checks++; if (result !== 8'h10) begin fails++; $display("[TB] FAIL cont_result1: got %0h expected 10", result); end
    v = 8'hE7;
    @(negedge clk);
    checks++; if (dac_code !== 8'h80 || busy !== 1'b1 || done !== 1'b0) begin fails++; $display("[TB] FAIL cont_no_gap: got dac %0h busy %0b done %0b expected 80 1 0", dac_code, busy, done); end
    continuous = 1'b0;
    wait_done(60, n, seen);
    checks++; if (!seen || n != 40) begin fails++; $display("[TB] FAIL cont_latency2: got %0d expected 40", n); end
    checks++; if (result !== 8'hE7) begin fails++; $display("[TB] FAIL cont_result2: got %0h expected e7", result); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL cont_stop: got busy %0b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    v     = 8'($urandom_range(0, 255));
    start = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dac_code !== 8'h00) begin fails++; $display("[TB] FAIL midreset_dac: got %0h expected 0", dac_code); end
    checks++; if (result !== 8'h00) begin fails++; $display("[TB] FAIL midreset_result: got %0h expected 0", result); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL midreset_flags: got busy %0b done %0b expected 0 0", busy, done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_single(8'($urandom_range(0, 255)));
  endtask

  task automatic test_small_config(input logic [5:0] val);
    int         n;
    bit         seen;
    logic [7:0] exp_trial;
    v6     = val;
    start6 = 1'b1;
    n      = 0;
    seen   = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) start6 = 1'b0;
      if (n <= 16 && (n - 1) % 3 == 0) begin
        exp_trial = sar_trial({2'b00, val}, 6, (n - 1) / 3);
        checks++;
        if ({2'b00, dac6} !== exp_trial) begin
          fails++;
          $display("[TB] FAIL w6_trial_%0d (V=%0h): got %0h expected %0h", (n - 1) / 3, val, dac6, exp_trial);
        end
      end
      if (done6) seen = 1'b1;
    end
    checks++; if (!seen || n != 19) begin fails++; $display("[TB] FAIL w6_latency (V=%0h): got %0d expected 18", val, n - 1); end
    checks++; if (result6 !== val) begin fails++; $display("[TB] FAIL w6_result: got %0h expected %0h", result6, val); end
    @(negedge clk);
    checks++; if (done6 !== 1'b0 || busy6 !== 1'b0) begin fails++; $display("[TB] FAIL w6_after_done: got done %0b busy %0b expected 0 0", done6, busy6); end
  endtask

  // Test sequence
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    v          = 8'h00;
    start6     = 1'b0;
    cont6      = 1'b0;
    v6         = 6'h00;
    test_reset();
    $display("[TB] single conversion V=a5");
    test_single(8'hA5);
    test_boundaries();
    test_random();
    test_start_held();
    test_continuous();
    test_reset_mid();
    test_small_config(6'h2A);
    test_small_config(6'($urandom_range(0, 63)));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation controller that turns the on-chip differential amplifier / OTA into an N-bit ADC. It drives an off-macro R-2R DAC code through uo_out; the DAC output feeds the amplifier's vin_n input. It reads the amplifier output, used as a comparator, back through a ui_in pin. The block sits directly upstream of the amplifier (it drives the reference input) and directly downstream of it (it consumes the comparator decision). It is instantiated in the top-level wrapper beside the analog subcircuits.

Parameters:
WIDTH, 8, resolution in bits; dac_code and result width.
SETTLE_CYCLES, 4, clk cycles allowed for DAC/amplifier settling per bit; legal range 2..15. The minimum of 2 covers the synchroniser.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level; begins a conversion when sampled high in IDLE
continuous  input  1  when high, a new conversion starts automatically after each DONE
cmp_in  input  1  asynchronous comparator output (1 = vin_p >= DAC voltage)
dac_code  output  WIDTH  trial code to the R-2R DAC
result  output  WIDTH  last completed conversion
busy  output  1  high from conversion accept until DONE inclusive
done  output  1  one-cycle pulse; result is updated in the same cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low. All flops clear immediately on rst_n low.
- Reset values: state=IDLE, dac_code=0, result=0, busy=0, done=0, both synchroniser flops=0, settle counter=0, bit index=WIDTH-1.
- Synchroniser: cmp_in passes through 2 flops to give cmp_sync. Only cmp_sync is ever used.
- IDLE:
  - Condition: start=1 or continuous=1.
  - Actions: dac_code <= 1 followed by WIDTH-1 zeros (MSB set), bit index <= WIDTH-1, counter <= SETTLE_CYCLES-1, busy <= 1, state <= SETTLE.
  - Otherwise dac_code holds its value, which is the last result after the first conversion.
- SETTLE: counter decrements each cycle. When the counter = 0, state <= DECIDE. This state lasts SETTLE_CYCLES cycles.
- DECIDE (one cycle), acting on dac_code[bit index]:
  - If cmp_sync=0, clear dac_code[bit index]. If cmp_sync=1, keep it.
  - If bit index > 0: set dac_code[bit index-1], decrement bit index, reload counter, state <= SETTLE.
  - If bit index = 0: result <= final code (including the LSB decision), state <= DONE.
- DONE (one cycle): done=1, busy=1.
  - If continuous=1, perform the IDLE accept actions directly (no IDLE cycle).
  - Else state <= IDLE, busy <= 0.
- Latency: start sampled at edge E0 gives done high after edge E0 + WIDTH*(SETTLE_CYCLES+1). With defaults this is 40 cycles.
- Inputs during a conversion: start is ignored while busy. Deasserting start mid-conversion has no effect. continuous is sampled only in DONE and IDLE.
- result changes only on entry to DONE and holds otherwise. dac_code after DONE equals result.
- Boundaries:
  - All-ones result: every bit kept.
  - All-zero result: every bit cleared. dac_code reaches 0 in the final DECIDE.
- rst_n asserted mid-conversion: immediate return to reset values. No done pulse, and result is cleared.
- Error cases: none flagged. cmp_in metastability is absorbed by the synchroniser.

Test Plan:
1. Bench model drives cmp_in = (V >= dac_code), with V=0xA5 and a single start pulse.
   - dac_code sequence at each SETTLE entry: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
   - done high exactly 40 cycles after accept; result=0xA5; busy falls the next cycle.
2. V=0x00 -> result=0x00. V=0xFF -> result=0xFF. Each done pulse is exactly one cycle wide.
3. start held high throughout, continuous=0, V=0x3C:
   - first conversion returns 0x3C, then one IDLE cycle, then the next conversion starts (start still high).
   - start toggling while busy does not alter the sequence.
4. continuous=1, V changes 0x10 -> 0xE7 between conversions:
   - back-to-back results 0x10 then 0xE7.
   - dac_code=0x80 in the cycle after the first done, with no IDLE gap.
5. rst_n pulsed low during bit 4's SETTLE:
   - all outputs 0 asynchronously, before the next clk edge.
   - after release, a new start yields a correct full conversion.
6. SETTLE_CYCLES=2, WIDTH=6, V=0x2A -> result=0x2A, done 18 cycles after accept.
